// File: rtl/adder_stream_acc.sv
// Packet accumulator that streams 16-bit words through an external adder and
// presents {acc_hi, acc_lo}, a saturating word count and a sticky overflow flag.
module adder_stream_acc #(
  parameter int HI_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_data,
  input  logic                 in_last,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  output logic                 add_cin,
  input  logic [16:0]          add_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16+HI_W-1:0]   out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf,
  output logic                 state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; ready never depends on valid, and valid never depends on ready.
  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       acc_lo;
  logic [HI_W-1:0]   acc_hi;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              in_fire;
  logic              out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 16'h0000;
    add_b     = 16'h0000;
    add_cin   = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        add_a    = acc_lo;
        add_b    = in_data;
        if (in_valid && in_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_lo <= '0;
      acc_hi <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (out_fire) begin
      acc_lo <= '0;
      acc_hi <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (in_fire) begin
      acc_lo <= add_sum[15:0];
      acc_hi <= acc_hi + HI_W'(add_sum[16]);
      if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
      // Carry out of a full upper field means the true sum no longer fits.
      if ((&acc_hi) && add_sum[16]) ovf <= 1'b1;
    end
  end

  assign out_sum   = {acc_hi, acc_lo};
  assign out_count = count;
  assign out_ovf   = ovf;
  assign state_dbg = state;

endmodule

// File: tb/tb_adder_stream_acc.sv
// Bench for adder_stream_acc: models the external adder, drives packets and
// checks results against a queue of expected {sum, count, ovf} values.
module tb_adder_stream_acc;

  localparam int HI_W  = 8;
  localparam int CNT_W = 8;
  localparam int SUM_W = 16 + HI_W;
  localparam int EXP_W = SUM_W + CNT_W + 1;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic              in_last;
  logic [15:0]       add_a;
  logic [15:0]       add_b;
  logic              add_cin;
  logic [16:0]       add_sum;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;
  logic              state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [15:0]      pkt[$];

  adder_stream_acc #(.HI_W(HI_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf),
    .state_dbg(state_dbg)
  );

  // External combinational adder.
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives pkt[] (last flag on final word), with up to gap_max idle cycles
  // between words, and pushes the model result. Entered and left on a negedge.
  task automatic drive_packet(input int gap_max);
    longint total = 0;
    int     cnt   = 0;
    int     t;
    for (int i = 0; i < pkt.size(); i++) begin
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == pkt.size() - 1);
      total += longint'(pkt[i]);
      if (cnt < 255) cnt++;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
      if (i != pkt.size() - 1) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
    exp_q.push_back({total[SUM_W-1:0], CNT_W'(cnt), (total >= (64'd1 << SUM_W))});
  endtask

  // Waits (bounded) for a result, captures it and consumes it.
  task automatic collect(output logic [EXP_W-1:0] got, output bit ok);
    int t = 0;
    ok  = 1'b0;
    got = '0;
    while (!out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (out_valid) begin
      got = {out_sum, out_count, out_ovf};
      ok  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++;
    if ({out_sum, out_count, out_ovf} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=%h/%0d/%b exp=0/0/0", out_sum, out_count, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_three_word();
    logic [EXP_W-1:0] got, exp;
    bit ok;
    pkt = '{16'hFFFF, 16'h0001, 16'h0010};
    drive_packet(0);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL three_latency out_valid got=%b exp=1", out_valid); end
    n_checks++;
    if (out_sum !== 24'h010010) begin n_fail++; $display("FAIL three_sum got=%h exp=010010", out_sum); end
    collect(got, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin n_fail++; $display("FAIL three_result got=%h exp=%h ok=%b", got, exp, ok); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL three_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_backpressure();
    logic [EXP_W-1:0] got, exp;
    bit ok;
    pkt = '{16'h1234};
    drive_packet(0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_last  = 1'b1;
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 24'h001234 || out_count !== 8'd1) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d got v=%b sum=%h cnt=%0d exp v=1 sum=001234 cnt=1", c, out_valid, out_sum, out_count);
      end
      n_checks++;
      if (in_ready !== 1'b0 || add_a !== 16'h0 || add_b !== 16'h0 || add_cin !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_idle cyc=%0d got rdy=%b a=%h b=%h cin=%b exp 0/0/0/0", c, in_ready, add_a, add_b, add_cin);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect(got, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin n_fail++; $display("FAIL single_result got=%h exp=%h ok=%b", got, exp, ok); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_overflow();
    logic [EXP_W-1:0] got, exp;
    bit ok;
    pkt = {};
    for (int i = 0; i < 257; i++) pkt.push_back(16'hFFFF);
    drive_packet(0);
    n_checks++;
    if (out_ovf !== 1'b1 || out_count !== 8'd255 || out_sum !== 24'h00FEFF) begin
      n_fail++;
      $display("FAIL ovf_const got ovf=%b cnt=%0d sum=%h exp 1/255/00FEFF", out_ovf, out_count, out_sum);
    end
    collect(got, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin n_fail++; $display("FAIL ovf_result got=%h exp=%h ok=%b", got, exp, ok); end
  endtask

  task automatic test_reset_mid_packet();
    logic [EXP_W-1:0] got, exp;
    bit ok;
    bit seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 16'h7777; in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_sum !== '0 || out_count !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset got sum=%h cnt=%0d rdy=%b exp 0/0/1", out_sum, out_count, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL reset_no_pulse got out_valid=1 exp=0"); end
    pkt = '{16'h0005, 16'h0003};
    drive_packet(0);
    collect(got, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp || got[EXP_W-1 -: SUM_W] !== 24'h000008) begin
      n_fail++; $display("FAIL post_reset_result got=%h exp=%h ok=%b", got, exp, ok);
    end
  endtask

  task automatic test_gapped();
    logic [EXP_W-1:0] got, exp;
    bit ok;
    // Adder operands visible while a word is offered in ACC.
    in_valid = 1'b1; in_data = 16'h0100; in_last = 1'b0;
    #1;
    n_checks++;
    if (add_a !== 16'h0 || add_b !== 16'h0100 || add_cin !== 1'b0) begin
      n_fail++; $display("FAIL add_ports got a=%h b=%h cin=%b exp 0000/0100/0", add_a, add_b, add_cin);
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = 16'hDEAD; in_last = 1'b1;
    @(negedge clk);
    n_checks++;
    if (add_a !== 16'h0100 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL gap_hold got a=%h v=%b exp 0100/0", add_a, out_valid);
    end
    pkt = '{16'h0100, 16'h0100, 16'h0100};
    drive_packet(2);
    void'(exp_q.pop_back());
    exp_q.push_back({24'h000400, 8'd4, 1'b0});
    collect(got, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) begin n_fail++; $display("FAIL gapped_result got=%h exp=%h ok=%b", got, exp, ok); end
  endtask

  task automatic test_back_to_back();
    logic [EXP_W-1:0] got, exp;
    bit ok;
    for (int p = 0; p < 4; p++) begin
      pkt = {};
      repeat ($urandom_range(1, 6)) pkt.push_back(16'($urandom));
      drive_packet(p % 2);
      collect(got, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || got !== exp) begin n_fail++; $display("FAIL random_pkt%0d got=%h exp=%h ok=%b", p, got, exp, ok); end
    end
  endtask

  initial begin
    test_reset();
    test_three_word();
    test_single_backpressure();
    test_overflow();
    test_reset_mid_packet();
    test_gapped();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_expected got=%0d exp=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_stream_acc.md
ADDER_STREAM_ACC -- requirements
Module: adder_stream_acc

Interface
REQ-001 SHALL have parameter HI_W, default 8: width of the carry-extension (upper) accumulator field.
REQ-002 SHALL have parameter CNT_W, default 8: width of the per-packet word counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  input word valid.
REQ-007 in_ready  out  1  block can accept an input word.
REQ-008 in_data  in  16  operand word.
REQ-009 in_last  in  1  marks the final word of a packet; qualified by the in_valid & in_ready handshake.
REQ-010 add_a  out  16  operand A driven to the external combinational 16-bit adder.
REQ-011 add_b  out  16  operand B driven to the external adder.
REQ-012 add_cin  out  1  carry-in driven to the external adder.
REQ-013 add_sum  in  17  adder result {cout, sum[15:0]}, combinational in the same cycle.
REQ-014 out_valid  out  1  result valid.
REQ-015 out_ready  in  1  downstream accepts the result.
REQ-016 out_sum  out  16+HI_W  packet sum, {acc_hi, acc_lo}.
REQ-017 out_count  out  CNT_W  number of words in the packet, saturating.
REQ-018 out_ovf  out  1  sticky flag: the sum exceeded 16+HI_W bits.

Function
REQ-019 SHALL implement a two-state FSM with states ACC and DONE.
REQ-020 in_ready SHALL equal (state==ACC), decoded from registered state only.
REQ-021 In ACC, SHALL drive add_a=acc_lo, add_b=in_data and add_cin=0; in DONE, SHALL drive add_a, add_b and add_cin to 0.
REQ-022 On an input handshake, SHALL perform all of the following:
- acc_lo <= add_sum[15:0];
- acc_hi <= acc_hi + add_sum[16], modulo 2^HI_W.
REQ-023 On a handshake where acc_hi is all-ones and add_sum[16]=1, SHALL set ovf; ovf SHALL remain set until the result is consumed or reset.
REQ-024 On each handshake, SHALL increment count, saturating at 2^CNT_W-1 with no wrap.
REQ-025 On a handshake with in_last=1, SHALL update the accumulators with that word and move to DONE; out_valid SHALL rise in the next cycle (latency 1 from the last handshake).
REQ-026 In DONE, SHALL behave as follows:
- out_valid=1;
- out_sum, out_count and out_ovf SHALL reflect the final registered values and hold stable while out_ready=0.
REQ-027 On the DONE-state cycle where out_ready=1, SHALL clear acc_lo, acc_hi, count and ovf, and return to ACC; in_ready SHALL be 1 in the following cycle.
REQ-028 SHALL NOT overlap input acceptance with output presentation; in_ready SHALL be 0 throughout DONE.
REQ-029 In ACC, out_valid SHALL be 0; out_sum, out_count and out_ovf SHALL be don't-care but driven from registers, with no combinational path from in_* to out_*.
REQ-030 in_valid=0 in ACC SHALL leave all state unchanged; a packet MAY span any number of idle cycles.
REQ-031 in_data and in_last SHALL be ignored when the handshake does not occur.

Reset
REQ-032 While rst_n=0, SHALL hold:
- state=ACC;
- acc_lo=0, acc_hi=0, count=0, ovf=0;
- out_valid=0, out_sum=0, out_count=0, out_ovf=0;
- in_ready=1.
REQ-033 Assertion of rst_n mid-packet or mid-DONE SHALL discard the partial result immediately (asynchronously); no out_valid pulse SHALL follow.
REQ-034 Deassertion SHALL take effect at the first clk edge after rst_n rises; the first packet SHALL then accumulate from zero.

Verification
REQ-035 Three-word packet 0xFFFF, 0x0001, 0x0010 (last on the third) -> out_valid one cycle after the third handshake; out_sum=0x010010, out_count=3, out_ovf=0.
REQ-036 Single-word packet 0x1234 with in_last=1 -> out_sum=0x001234, out_count=1; in_ready=0 until out_ready=1, then 1 in the next cycle.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_count stable; in_ready=0 and add_a=add_b=0 throughout.
REQ-038 Overflow: 257 words of 0xFFFF -> out_ovf=1, out_count=255 (saturated), out_sum=0x00FEFF (modulo 2^24).
REQ-039 Reset after 2 words of a packet, then a new packet 0x0005, 0x0003(last) -> out_sum=0x000008, out_count=2, out_ovf=0.
REQ-040 Gapped input: in_valid toggled 1-0-1 across a 4-word packet of 0x0100 -> out_sum=0x000400, out_count=4.
